uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised full-duplex UART for the pipelined SoC: configurable data width, parity and stop-bit count, with error reporting.
- TX side uses a valid/ready handshake that is accepted on any clock, not only on baud ticks.
- RX side synchronises the line, samples at bit centre with 3-sample majority vote, and flags framing and parity errors.
- Sits between the host-programming/debug logic and the board serial pins.

Parameters:
- CLK_FREQ, 50_000_000: system clock in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- OVERSAMPLE, 16: baud ticks per bit; even, at least 8.
- DATA_BITS, 8: payload width; legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2, TX side only. RX always checks exactly one stop bit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  send request
- tx_ready  out  1  high when transmitter idle; transfer occurs when tx_valid && tx_ready
- tx  out  1  serial out, idle high
- rx  in  1  serial in, asynchronous to clk
- rx_data  out  DATA_BITS  last received word
- rx_valid  out  1  one-clk pulse, word complete
- rx_frame_err  out  1  stop bit sampled low; qualified by rx_valid
- rx_parity_err  out  1  parity mismatch; qualified by rx_valid; always 0 when PARITY=0

Behaviour:
- Reset is asynchronous and active-high. Reset values: tx=1, tx_ready=1, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0. Both FSMs go to IDLE, all counters clear, both synchroniser flops set to 1.
- Reset mid-frame aborts immediately; tx is high in the same cycle.
- Baud generator:
  - BAUD_DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded; minimum 1.
  - Counter width is $clog2(BAUD_DIV+1).
  - One-clk tick when the counter wraps; free-running and shared by TX and RX.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Handshake accepted in any cycle: data is latched and tx_ready drops on the next edge. The FSM enters START, and its tick counter resyncs to 0 at acceptance.
  - Each bit lasts exactly OVERSAMPLE ticks. Data is sent LSB first.
  - PARITY state is skipped when PARITY=0. Parity bit is the XOR of the data bits; odd parity inverts it.
  - STOP lasts STOP_BITS*OVERSAMPLE ticks. tx_ready rises in the clk after the last stop tick.
  - tx_valid while tx_ready=0 is ignored; tx_data is not sampled.
  - tx is registered; no glitches.
- RX FSM (IDLE, START, DATA, PARITY, STOP, BREAK):
  - rx passes through a 2-flop synchroniser first.
  - IDLE: a low sample on a tick enters START with tick count 0.
  - Majority vote uses samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
  - START: if the start-bit vote is 1, the start is false; return to IDLE with no output.
  - DATA: shift in DATA_BITS bits, LSB first, then PARITY if enabled, then STOP.
  - At the vote point of the stop bit (centre, not bit end): latch rx_data, set the error flags, pulse rx_valid for exactly one clk.
  - Stop vote 1: go to IDLE. Stop vote 0: set frame error and go to BREAK. BREAK waits for a synchronised 1 on a tick, then goes to IDLE.
  - A new rx_valid overwrites rx_data; there is no buffering and no overrun flag.
- TX and RX are independent. Simultaneous activity on both has no interaction.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: extra port loopback (in, 1).
  - When 1, the RX synchroniser input is the internal tx register instead of pin rx.
  - Pin tx still drives normally.
  - Switching loopback mid-frame is undefined. Change it only when tx_ready=1 and RX is IDLE.
- Undefined: no loopback port; RX always uses pin rx.

Test Plan:
- Setup for all scenarios: CLK_FREQ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16, so BAUD_DIV=1 and 1 bit = 16 clks.
- TX 8N1, DATA_BITS=8, PARITY=0, STOP_BITS=1: tx_data=0xA5, tx_valid 1 clk.
  -> tx_ready low next clk; tx low 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each; stop high; tx_ready high 160 clks after acceptance.
- TX 8E2, PARITY=1, STOP_BITS=2: send 0x07.
  -> parity bit 1; stop high 32 clks; frame is 192 clks.
- RX 8O1, PARITY=2: drive 0x3C with correct odd parity (bit 1).
  -> one rx_valid pulse, rx_data=0x3C, both errors 0.
  - Repeat with parity bit flipped -> rx_parity_err=1 with rx_valid.
- RX framing/break: drive 0x55, then hold rx low for 3 bit times.
  -> rx_valid with rx_frame_err=1, rx_data=0x55.
  - No further rx_valid until rx returns high; then a frame 0x81 is received cleanly.
- Glitch rejection and reset: 4-clk low pulse on rx -> no rx_valid.
  - Assert reset mid-TX of 0xFF -> tx=1 and tx_ready=1 asynchronously.
  - After release, a send of 0x12 completes normally.
- UART_LOOPBACK_EN, loopback=1, rx pin held high: send 0xC3, 0x00, 0xFF back-to-back.
  -> three rx_valid pulses with matching rx_data, no errors.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART with a valid/ready TX side,
// a majority-voting RX side, and framing/parity error reporting.
// Optional build macro UART_LOOPBACK_EN adds a 'loopback' input that routes
// the internal tx register into the RX synchroniser in place of pin rx.
//
// TX states   | meaning
//   TX_IDLE   | line high, tx_ready asserted, waiting for handshake
//   TX_START  | driving start bit (low)
//   TX_DATA   | driving data bits LSB first
//   TX_PARITY | driving parity bit (only when PARITY != 0)
//   TX_STOP   | driving STOP_BITS stop bits (high)
// RX states   | meaning
//   RX_IDLE   | waiting for a low sample on a tick
//   RX_START  | checking the start bit, false start returns to idle
//   RX_DATA   | shifting in data bits LSB first
//   RX_PARITY | capturing the parity bit
//   RX_STOP   | reporting the word at the stop-bit vote
//   RX_BREAK  | line held low after a framing error, wait for high
module uart_core_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int BAUD_DIV_RAW = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int BAUD_DIV     = (BAUD_DIV_RAW < 1) ? 1 : BAUD_DIV_RAW;
  localparam int BDW          = $clog2(BAUD_DIV + 1);
  localparam int HALF         = OVERSAMPLE / 2;
  localparam int RCW          = $clog2(OVERSAMPLE);
  localparam int TCW          = $clog2(STOP_BITS * OVERSAMPLE);
  localparam int BW           = $clog2(DATA_BITS);
  localparam logic ODD        = (PARITY == 2);

  // Free-running baud down-counter; tick on terminal count, shared by TX and RX.
  logic [BDW-1:0] baud_cnt;
  logic           tick;
  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     baud_cnt <= '0;
    else if (tick) baud_cnt <= BDW'(BAUD_DIV - 1);
    else           baud_cnt <= baud_cnt - 1'b1;
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state, tx_state_d;
  logic [TCW-1:0]       tx_cnt, tx_cnt_d;
  logic [BW-1:0]        tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_buf, tx_buf_d;
  logic                 tx_q, tx_d;
  logic                 tx_done;

  assign tx_done  = tick && (tx_cnt == '0);
  assign tx       = tx_q;
  assign tx_ready = (tx_state == TX_IDLE);

  // TX next state; tx_d is the line level for the state being entered so tx stays registered.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_buf_d   = tx_buf;
    tx_d       = tx_q;
    case (tx_state)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          tx_buf_d   = tx_data;
          tx_cnt_d   = TCW'(OVERSAMPLE - 1);
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START, TX_DATA, TX_PARITY, TX_STOP: begin
        if (tick && !tx_done) tx_cnt_d = tx_cnt - 1'b1;
        if (tx_done) begin
          tx_cnt_d = TCW'(OVERSAMPLE - 1);
          if (tx_state == TX_START) begin
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
            tx_d       = tx_buf[0];
          end else if (tx_state == TX_DATA && tx_bit != BW'(DATA_BITS - 1)) begin
            tx_bit_d = tx_bit + 1'b1;
            tx_d     = tx_buf[tx_bit + 1'b1];
          end else if (tx_state == TX_DATA && PARITY != 0) begin
            tx_state_d = TX_PARITY;
            tx_d       = (^tx_buf) ^ ODD;
          end else if (tx_state != TX_STOP) begin
            tx_cnt_d   = TCW'(STOP_BITS * OVERSAMPLE - 1);
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state register; reset drives the line high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_buf   <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_buf   <= tx_buf_d;
      tx_q     <= tx_d;
    end
  end

  // ---------------- receiver ----------------
  logic rx_in, rx_s1, rx_s2;
`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_q : rx;
`else
  assign rx_in = rx;
`endif

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t            rx_state, rx_state_d;
  logic [RCW-1:0]       rx_cnt, rx_cnt_d;
  logic [BW-1:0]        rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d, rx_data_d;
  logic                 rx_v0, rx_v0_d, rx_v1, rx_v1_d, rx_par, rx_par_d;
  logic                 rx_valid_d, fe_d, pe_d;
  logic                 rx_at_vote, rx_at_end, vote;

  assign rx_at_vote = tick && (rx_cnt == RCW'(HALF + 1));
  assign rx_at_end  = tick && (rx_cnt == RCW'(OVERSAMPLE - 1));
  assign vote       = (rx_v0 & rx_v1) | (rx_v0 & rx_s2) | (rx_v1 & rx_s2);

  // RX next state: bit timing, 3-sample majority vote, word and error reporting.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_v0_d    = rx_v0;
    rx_v1_d    = rx_v1;
    rx_par_d   = rx_par;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    fe_d       = rx_frame_err;
    pe_d       = rx_parity_err;
    if (tick && rx_state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}) begin
      rx_cnt_d = rx_at_end ? '0 : rx_cnt + 1'b1;
      if (rx_cnt == RCW'(HALF - 1)) rx_v0_d = rx_s2;
      if (rx_cnt == RCW'(HALF))     rx_v1_d = rx_s2;
    end
    case (rx_state)
      RX_IDLE: begin
        if (tick && !rx_s2) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_at_vote && vote) rx_state_d = RX_IDLE;
        else if (rx_at_end) begin
          rx_bit_d   = '0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_at_vote) rx_sh_d = {vote, rx_sh[DATA_BITS-1:1]};
        if (rx_at_end) begin
          if (rx_bit != BW'(DATA_BITS - 1)) rx_bit_d = rx_bit + 1'b1;
          else if (PARITY != 0)             rx_state_d = RX_PARITY;
          else                              rx_state_d = RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_at_vote) rx_par_d = vote;
        if (rx_at_end)  rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        // Report at the stop-bit centre so the next start edge is never missed.
        if (rx_at_vote) begin
          rx_data_d  = rx_sh;
          rx_valid_d = 1'b1;
          fe_d       = !vote;
          pe_d       = (PARITY != 0) && (rx_par != ((^rx_sh) ^ ODD));
          rx_state_d = vote ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (tick && rx_s2) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX synchroniser, state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_v0         <= 1'b1;
      rx_v1         <= 1'b1;
      rx_par        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_s1         <= rx_in;
      rx_s2         <= rx_s1;
      rx_state      <= rx_state_d;
      rx_cnt        <= rx_cnt_d;
      rx_bit        <= rx_bit_d;
      rx_sh         <= rx_sh_d;
      rx_v0         <= rx_v0_d;
      rx_v1         <= rx_v1_d;
      rx_par        <= rx_par_d;
      rx_data       <= rx_data_d;
      rx_valid      <= rx_valid_d;
      rx_frame_err  <= fe_d;
      rx_parity_err <= pe_d;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: 8N1 / 8E2 transmit, 8O1 and 8N1
// receive with error cases, glitch rejection, async reset and, when built
// with UART_LOOPBACK_EN, a loopback run. 1 bit = 16 clks.
module tb_uart_core_param;
  localparam int CF = 1_600_000;
  localparam int BR = 100_000;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic rx_line = 1'b1;

  logic [7:0] tx_data_a = '0, tx_data_b = '0, tx_data_c = '0;
  logic tx_valid_a = 1'b0, tx_valid_b = 1'b0, tx_valid_c = 1'b0;
  logic tx_ready_a, tx_ready_b, tx_ready_c, tx_a, tx_b, tx_c;
  logic [7:0] rx_data_a, rx_data_b, rx_data_c;
  logic rx_valid_a, rx_valid_b, rx_valid_c;
  logic fe_a, fe_b, fe_c, pe_a, pe_b, pe_c;
`ifdef UART_LOOPBACK_EN
  logic lb_a = 1'b0;
`endif

  // 8N1
  uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .loopback(lb_a),
`endif
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a), .rx(rx_line),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a));

  // 8E2
  uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b), .rx(1'b1),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b));

  // 8O1
  uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .tx(tx_c), .rx(rx_line),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_frame_err(fe_c), .rx_parity_err(pe_c));

  int checks = 0;
  int failures = 0;

  logic [7:0] qd_a[$], qd_c[$];
  logic qf_a[$], qp_a[$], qf_c[$], qp_c[$];

  always @(negedge clk) begin
    if (rx_valid_a) begin qd_a.push_back(rx_data_a); qf_a.push_back(fe_a); qp_a.push_back(pe_a); end
    if (rx_valid_c) begin qd_c.push_back(rx_data_c); qf_c.push_back(fe_c); qp_c.push_back(pe_c); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int s);
    return (s == 1) ? tx_b : tx_a;
  endfunction

  function automatic logic rdy_of(input int s);
    return (s == 1) ? tx_ready_b : tx_ready_a;
  endfunction

  task automatic drive_tx(input int s, input logic [7:0] d, input logic v);
    if (s == 1) begin tx_data_b = d; tx_valid_b = v; end
    else        begin tx_data_a = d; tx_valid_a = v; end
  endtask

  // One handshake, then sample every bit at its centre; n counts negedges after the accept edge.
  task automatic check_tx(input int s, input logic [7:0] d, input int has_par, input logic pbit, input int nstop);
    logic [7:0] obs;
    obs = '0;
    drive_tx(s, d, 1'b1);
    @(negedge clk);
    drive_tx(s, d, 1'b0);
    check("tx_ready_drop", rdy_of(s), 1'b0);
    check("tx_start_edge", tx_of(s), 1'b0);
    repeat (8) @(negedge clk);
    check("tx_start_mid", tx_of(s), 1'b0);
    drive_tx(s, ~d, 1'b1);        // must be ignored while busy
    @(negedge clk);
    drive_tx(s, ~d, 1'b0);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (16) @(negedge clk);
      obs[i] = tx_of(s);
    end
    check("tx_data_bits", obs, d);
    if (has_par != 0) begin
      repeat (16) @(negedge clk);
      check("tx_parity_bit", tx_of(s), pbit);
    end
    for (int k = 0; k < nstop; k++) begin
      repeat (16) @(negedge clk);
      check("tx_stop_bit", tx_of(s), 1'b1);
    end
    repeat (7) @(negedge clk);
    check("tx_ready_before_end", rdy_of(s), 1'b0);
    @(negedge clk);
    check("tx_ready_at_end", rdy_of(s), 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic has_par, input logic pbit, input logic stopv);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (16) @(negedge clk);
    end
    if (has_par) begin
      rx_line = pbit;
      repeat (16) @(negedge clk);
    end
    rx_line = stopv;
    repeat (16) @(negedge clk);
  endtask

  task automatic check_rx(input int s, input string tag, input int expn, input logic [7:0] d, input logic f, input logic p);
    int n;
    n = (s == 2) ? qd_c.size() : qd_a.size();
    check({tag, "_count"}, n, expn);
    if (n > 0) begin
      if (s == 2) begin
        check({tag, "_data"}, qd_c[n-1], d);
        check({tag, "_frame_err"}, qf_c[n-1], f);
        check({tag, "_parity_err"}, qp_c[n-1], p);
      end else begin
        check({tag, "_data"}, qd_a[n-1], d);
        check({tag, "_frame_err"}, qf_a[n-1], f);
        check({tag, "_parity_err"}, qp_a[n-1], p);
      end
    end
  endtask

`ifdef UART_LOOPBACK_EN
  logic [7:0] lb_bytes [3] = '{8'hC3, 8'h00, 8'hFF};
`endif

  initial begin
    int base_a, base_c;
    #1 reset = 1'b1;
    #2;
    check("rst_tx", tx_a, 1'b1);
    check("rst_tx_ready", tx_ready_a, 1'b1);
    check("rst_rx_data", rx_data_a, 8'h00);
    check("rst_rx_valid", rx_valid_a, 1'b0);
    check("rst_frame_err", fe_a, 1'b0);
    check("rst_parity_err", pe_a, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: frame 160 clks
    check_tx(0, 8'hA5, 0, 1'b0, 1);
    // 8E2 0x07: three ones -> even parity bit 1, frame 192 clks
    check_tx(1, 8'h07, 1, 1'b1, 2);

    // 8O1 0x3C: four ones -> odd parity bit 1
    repeat (20) @(negedge clk);
    base_c = qd_c.size();
    send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check_rx(2, "rx_odd_ok", base_c + 1, 8'h3C, 1'b0, 1'b0);
    base_c = qd_c.size();
    send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check_rx(2, "rx_odd_bad", base_c + 1, 8'h3C, 1'b0, 1'b1);

    // framing error and break on 8N1
    repeat (40) @(negedge clk);
    base_a = qd_a.size();
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (48) @(negedge clk);
    check_rx(0, "rx_break", base_a + 1, 8'h55, 1'b1, 1'b0);
    rx_line = 1'b1;
    repeat (32) @(negedge clk);
    send_rx(8'h81, 1'b0, 1'b0, 1'b1);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check_rx(0, "rx_after_break", base_a + 2, 8'h81, 1'b0, 1'b0);

    // 4-clk glitch is a false start
    base_a = qd_a.size();
    base_c = qd_c.size();
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_a_count", qd_a.size(), base_a);
    check("glitch_c_count", qd_c.size(), base_c);

    // async reset in the middle of a 0xFF transmit
    drive_tx(0, 8'hFF, 1'b1);
    @(negedge clk);
    drive_tx(0, 8'hFF, 1'b0);
    repeat (5) @(negedge clk);
    check("tx_before_reset", tx_a, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", tx_a, 1'b1);
    check("async_rst_tx_ready", tx_ready_a, 1'b1);
    check("async_rst_rx_data", rx_data_a, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_tx(0, 8'h12, 0, 1'b0, 1);

`ifdef UART_LOOPBACK_EN
    begin
      int n;
      repeat (10) @(negedge clk);
      lb_a = 1'b1;
      repeat (5) @(negedge clk);
      base_a = qd_a.size();
      for (int i = 0; i < 3; i++) begin
        n = 0;
        while (!tx_ready_a && n < 500) begin @(negedge clk); n++; end
        check("lb_ready_wait", tx_ready_a, 1'b1);
        drive_tx(0, lb_bytes[i], 1'b1);
        @(negedge clk);
        drive_tx(0, lb_bytes[i], 1'b0);
      end
      n = 0;
      while (qd_a.size() < base_a + 3 && n < 1000) begin @(negedge clk); n++; end
      check("lb_count", qd_a.size(), base_a + 3);
      if (qd_a.size() >= base_a + 3) begin
        for (int i = 0; i < 3; i++) begin
          check("lb_data", qd_a[base_a+i], lb_bytes[i]);
          check("lb_frame_err", qf_a[base_a+i], 1'b0);
          check("lb_parity_err", qp_a[base_a+i], 1'b0);
        end
      end
      lb_a = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
